// File: rtl/azadi_pad_ctrl.sv
// azadi_pad_ctrl -- per-pad I/O control with input synchronisation and debounce.
//
// Output path: core_out_i / core_oe_i / core_pull_en_i are registered onto the
// pad pins (io_out_o, active-low io_oeb_o, active-low io_ren_o) with one cycle
// of latency. pad_hold_i freezes these registers; reset overrides the hold.
//
// Input path: each io_in_i bit goes through a two-flop synchroniser (s1, s2),
// then a debounce filter that produces the filtered level core_in_o and
// single-cycle edge pulses rise_o / fall_o.
//
// Configuration macro: AZADI_PAD_FILTER_EN
//   defined   -> per-pad FILT_W-bit debounce counter compared against
//                filt_thresh_i; a new level is accepted once s2 has disagreed
//                with the filtered level for filt_thresh_i+1 consecutive edges.
//   undefined -> no counters; the filtered level follows s2 every cycle and
//                filt_thresh_i is ignored.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   filt_thresh_i [FILT_W]  debounce threshold shared by all pads
//   pad_hold_i              freeze pad-side output registers
//   core_out_i/oe_i/pull_en_i [NUM_PADS]  core-side output controls
//   core_in_o  [NUM_PADS]   filtered pad input
//   rise_o/fall_o [NUM_PADS] one-cycle filtered edge pulses
//   io_in_i    [NUM_PADS]   raw pad inputs
//   io_out_o/io_oeb_o/io_ren_o [NUM_PADS]  pad-side output pins
module azadi_pad_ctrl #(
  parameter int NUM_PADS = 54,
  parameter int FILT_W   = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [FILT_W-1:0]   filt_thresh_i,
  input  logic                pad_hold_i,
  input  logic [NUM_PADS-1:0] core_out_i,
  input  logic [NUM_PADS-1:0] core_oe_i,
  input  logic [NUM_PADS-1:0] core_pull_en_i,
  output logic [NUM_PADS-1:0] core_in_o,
  output logic [NUM_PADS-1:0] rise_o,
  output logic [NUM_PADS-1:0] fall_o,
  input  logic [NUM_PADS-1:0] io_in_i,
  output logic [NUM_PADS-1:0] io_out_o,
  output logic [NUM_PADS-1:0] io_oeb_o,
  output logic [NUM_PADS-1:0] io_ren_o
);

  logic [NUM_PADS-1:0] s1;
  logic [NUM_PADS-1:0] s2;
  logic [NUM_PADS-1:0] stable;

  // Output registers: reset tri-states the pads with pulls enabled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      io_out_o <= '0;
      io_oeb_o <= '1;
      io_ren_o <= '0;
    end else if (!pad_hold_i) begin
      io_out_o <= core_out_i;
      io_oeb_o <= ~core_oe_i;
      io_ren_o <= ~core_pull_en_i;
    end
  end

  // Two-flop synchroniser; keeps running while outputs are held.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= io_in_i;
      s2 <= s1;
    end
  end

`ifdef AZADI_PAD_FILTER_EN
  logic [FILT_W-1:0] cnt [NUM_PADS];

  // cnt only advances while below the threshold, so it can never wrap, and a
  // threshold lowered below the current count fires on the very next edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stable <= '0;
      rise_o <= '0;
      fall_o <= '0;
      for (int i = 0; i < NUM_PADS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PADS; i++) begin
        rise_o[i] <= 1'b0;
        fall_o[i] <= 1'b0;
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] >= filt_thresh_i) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
          rise_o[i] <= s2[i];
          fall_o[i] <= ~s2[i];
        end else begin
          cnt[i] <= cnt[i] + FILT_W'(1);
        end
      end
    end
  end
`else
  logic unused_thresh;
  assign unused_thresh = ^filt_thresh_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stable <= '0;
      rise_o <= '0;
      fall_o <= '0;
    end else begin
      stable <= s2;
      rise_o <= s2 & ~stable;
      fall_o <= ~s2 & stable;
    end
  end
`endif

  assign core_in_o = stable;

endmodule

// File: tb/tb_azadi_pad_ctrl.sv
// Testbench for azadi_pad_ctrl: randomized stimulus compared every cycle
// against a behavioural model, plus directed latency/bounce/threshold/hold cases.
module tb_azadi_pad_ctrl;
  localparam int NP = 54;
  localparam int FW = 8;
`ifdef AZADI_PAD_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] thresh;
  logic          hold;
  logic [NP-1:0] core_out, core_oe, core_pull, io_in;
  logic [NP-1:0] core_in, rise, fall, io_out, io_oeb, io_ren;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  azadi_pad_ctrl #(.NUM_PADS(NP), .FILT_W(FW)) dut (
    .clk_i(clk), .rst_i(rst), .filt_thresh_i(thresh), .pad_hold_i(hold),
    .core_out_i(core_out), .core_oe_i(core_oe), .core_pull_en_i(core_pull),
    .core_in_o(core_in), .rise_o(rise), .fall_o(fall), .io_in_i(io_in),
    .io_out_o(io_out), .io_oeb_o(io_oeb), .io_ren_o(io_ren)
  );

  // ---------------- reference model ----------------
  // Raw samples travel through a two-entry delay queue; a pad accepts a new
  // level once the delayed sample has disagreed with the accepted level for
  // more than thresh consecutive edges (every edge when the filter is absent).
  logic [NP-1:0] in_hist[$];
  int            disagree[NP];
  logic [NP-1:0] m_stable, m_rise, m_fall, m_out, m_oeb, m_ren;

  task automatic model_step();
    logic [NP-1:0] d;
    int            eff;
    if (rst) begin
      in_hist = {NP'(0), NP'(0)};
      foreach (disagree[p]) disagree[p] = 0;
      m_stable = '0; m_rise = '0; m_fall = '0;
      m_out = '0; m_oeb = '1; m_ren = '0;
    end else begin
      d = in_hist.pop_front();
      in_hist.push_back(io_in);
      eff = FILT ? int'(thresh) : 0;
      m_rise = '0;
      m_fall = '0;
      for (int p = 0; p < NP; p++) begin
        if (d[p] == m_stable[p]) disagree[p] = 0;
        else begin
          disagree[p] = disagree[p] + 1;
          if (disagree[p] > eff) begin
            m_stable[p] = d[p];
            m_rise[p]   = d[p];
            m_fall[p]   = ~d[p];
            disagree[p] = 0;
          end
        end
      end
      if (!hold) begin
        m_out = core_out;
        m_oeb = ~core_oe;
        m_ren = ~core_pull;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: inputs are already set (at the falling edge); update the model
  // at the rising edge, sample the DUT 1 time unit later, return at falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("core_in", core_in, m_stable);
    check("rise", rise, m_rise);
    check("fall", fall, m_fall);
    check("rise_fall_excl", rise & fall, '0);
    check("io_out", io_out, m_out);
    check("io_oeb", io_oeb, m_oeb);
    check("io_ren", io_ren, m_ren);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    core_oe = '1;
    cycle();
    cycle();
    check("rst_oeb", io_oeb, {NP{1'b1}});
    check("rst_ren", io_ren, '0);
    check("rst_out", io_out, '0);
    check("rst_edges", rise | fall, '0);
    rst = 1'b0;
  endtask

  function automatic logic [NP-1:0] rnd_vec();
    return NP'({$urandom, $urandom});
  endfunction

  // Edges from the sampling edge (counted as 1) to the rise pulse on pad.
  task automatic latency_test(input int pad, input logic [FW-1:0] th);
    int  n;
    bit  seen;
    io_in = '0; hold = 1'b0; thresh = th;
    do_reset();
    repeat (4) cycle();
    io_in[pad] = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < 300) begin
      cycle();
      n++;
      if (rise[pad]) seen = 1;
    end
    check("latency", 64'(n), FILT ? 64'(3 + int'(th)) : 64'd3);
    check("lat_only_pad", core_in, NP'(1) << pad);
    cycle();
    check("lat_pulse_once", rise, '0);
  endtask

  initial begin
    logic [NP-1:0] seen_rise;
    rst = 1'b1; thresh = '0; hold = 1'b0;
    core_out = '0; core_oe = '1; core_pull = '0; io_in = '0;
    @(negedge clk);
    do_reset();

    // Debounce latency, including the zero threshold.
    latency_test(5, 8'd3);
    latency_test(20, 8'd0);
    latency_test(53, 8'd7);

    // Bounce shorter than threshold: no transition on pad 7.
    thresh = 8'd4; io_in = '0;
    do_reset();
    repeat (3) cycle();
    seen_rise = '0;
    io_in[7] = 1'b1;
    repeat (3) begin cycle(); seen_rise |= rise; end
    io_in[7] = 1'b0;
    repeat (8) begin cycle(); seen_rise |= rise; end
    check("bounce_rise", 64'(seen_rise[7]), FILT ? 64'd0 : 64'd1);
    check("bounce_level", 64'(core_in[7]), 64'd0);

    // Threshold drop mid-count.
    thresh = 8'd200; io_in = '0;
    do_reset();
    io_in[3] = 1'b1;
    repeat (52) cycle();
    thresh = 8'd10;
    cycle();
    check("thresh_drop", 64'(core_in[3]), 64'd1);

    // Hold freezes the pad outputs, release loads on the next edge.
    core_out = '0;
    cycle();
    hold = 1'b1; core_out = NP'(8'h0F);
    repeat (3) cycle();
    check("hold_out", io_out, '0);
    hold = 1'b0;
    cycle();
    check("release_out", io_out, NP'(8'h0F));

    // Randomized traffic with rare mid-count resets.
    thresh = 8'd2;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 7) == 0) io_in[p] = ~io_in[p];
      if ($urandom_range(0, 49) == 0) thresh = FW'($urandom_range(0, 6));
      hold      = ($urandom_range(0, 7) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      core_out  = rnd_vec();
      core_oe   = rnd_vec();
      core_pull = rnd_vec();
      cycle();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0t exp=finish", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/azadi_pad_ctrl.md
AZADI_PAD_CTRL -- requirements
Module: azadi_pad_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_PADS, default 54, the number of pad channels.
REQ-002 The block SHALL have parameter FILT_W, default 8, the width of the per-pad debounce counter and threshold.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 The block SHALL have these ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- filt_thresh_i  input  FILT_W  debounce threshold, global to all pads
- pad_hold_i  input  1  freeze pad-side outputs
- core_out_i  input  NUM_PADS  data to drive onto pads
- core_oe_i  input  NUM_PADS  output enable, active-high
- core_pull_en_i  input  NUM_PADS  pull resistor enable, active-high
- core_in_o  output  NUM_PADS  synchronised, filtered pad input
- rise_o  output  NUM_PADS  one-cycle pulse on a filtered 0->1 transition
- fall_o  output  NUM_PADS  one-cycle pulse on a filtered 1->0 transition
- io_in_i  input  NUM_PADS  raw pad C pins
- io_out_o  output  NUM_PADS  pad I pins
- io_oeb_o  output  NUM_PADS  pad OEN pins, active-low
- io_ren_o  output  NUM_PADS  pad REN pins, active-low

Function
REQ-005 Output path SHALL be registered per pad: io_out_o<=core_out_i, io_oeb_o<=~core_oe_i, io_ren_o<=~core_pull_en_i; latency 1 cycle.
REQ-006 While pad_hold_i=1, io_out_o, io_oeb_o and io_ren_o SHALL keep their values; the input path SHALL keep running.
REQ-007 On the first edge after pad_hold_i falls, the output registers SHALL load the current core values.
REQ-008 Each pad input SHALL pass through a 2-flop synchroniser (s1, s2) before any other logic.
REQ-009 Per pad, the filter SHALL hold a stable bit and a FILT_W-bit counter cnt.
REQ-010 When s2==stable, cnt SHALL clear to 0.
REQ-011 When s2!=stable and cnt>=filt_thresh_i, the filter SHALL set stable<=s2 and cnt<=0.
REQ-012 When s2!=stable and cnt<filt_thresh_i, cnt SHALL increment.
REQ-013 Because the compare is >=, lowering filt_thresh_i mid-count SHALL take effect on the next edge, and cnt SHALL never wrap.
REQ-014 core_in_o SHALL equal stable.
REQ-015 If io_in_i changes and is sampled at edge t and then holds, stable SHALL update at edge t+2+filt_thresh_i.
REQ-016 A bounce that returns to the stable value before the threshold is reached SHALL clear cnt and produce no transition.
REQ-017 rise_o and fall_o SHALL be registered and assert for exactly one cycle on the same edge that stable updates (rise for 0->1, fall for 1->0).
REQ-018 rise_o and fall_o SHALL never assert together on one pad.
REQ-019 All pads SHALL be independent; simultaneous events on any pads SHALL be handled in parallel.

Reset
REQ-020 rst_i=1 at an edge SHALL override pad_hold_i and all other inputs.
REQ-021 On reset, io_oeb_o SHALL be all 1 (pads tri-stated).
REQ-022 On reset, io_ren_o SHALL be all 0 (pulls enabled).
REQ-023 On reset, io_out_o, s1, s2, stable, cnt, core_in_o, rise_o and fall_o SHALL be all 0.
REQ-024 Reset asserted mid-count SHALL discard pending transitions without emitting rise_o or fall_o.

Configuration
REQ-025 With macro AZADI_PAD_FILTER_EN defined, the debounce filter SHALL be present as in REQ-009..REQ-016.
REQ-026 Without AZADI_PAD_FILTER_EN, the counters SHALL be absent and filt_thresh_i ignored; stable<=s2 every cycle, so latency is t+2 and edges are still generated.

Verification
REQ-027 Reset: rst_i=1 for 2 cycles with core_oe_i all 1 -> io_oeb_o=all 1, io_ren_o=0, io_out_o=0, rise_o=fall_o=0.
REQ-028 Debounce: thresh=3, io_in_i[5] 0->1 at edge 10 and held -> core_in_o[5]=1 and rise_o[5]=1 for one cycle after edge 15; no other bit toggles.
REQ-029 Bounce: thresh=4, io_in_i[7] high for 3 cycles then low -> no rise_o[7], core_in_o[7] stays 0, cnt returns to 0.
REQ-030 Hold: core_out_i=0x0F while pad_hold_i=1 from io_out_o=0 -> io_out_o stays 0; release -> io_out_o=0x0F one edge later.
REQ-031 Threshold drop: thresh=200 and cnt=50, then thresh set to 10 -> stable updates on the next edge.
REQ-032 Macro off: io_in_i[0] 1->0 at edge t -> core_in_o[0]=0 and fall_o[0]=1 after edge t+2, regardless of filt_thresh_i.
